// File: rtl/svga_timing_gen.sv
// ---------------------------------------------------------------------------
// svga_timing_gen
//
// Configurable SVGA raster timing generator. A horizontal counter walks the
// pixels of a line and a vertical counter walks the lines of a frame; both
// advance only on cycles where the pixel enable is high. From the next-state
// position the block registers blanking (active) and the two sync outputs, so
// every output describes the same pixel as x_o / y_o in the same cycle.
//
// Optional feature: define SVGA_FRAME_COUNT_EN to add a FRAME_W-bit frame
// counter on frame_o (shader time base). Without the macro the port and its
// register do not exist.
//
// Ports:
//   clk_i            clock, all registers on the rising edge
//   rst_ni           asynchronous active-low reset
//   en_i             pixel enable; position advances only when high
//   x_o              current column, 0..H_TOTAL-1
//   y_o              current line, 0..V_TOTAL-1
//   active_o         high inside the visible area
//   hsync_o          horizontal sync, asserted level H_SYNC_POL
//   vsync_o          vertical sync, asserted level V_SYNC_POL
//   next_vertical_o  strobe: last pixel of a line is being left (comb.)
//   next_frame_o     strobe: last pixel of a frame is being left (comb.)
//   frame_o          frame count (SVGA_FRAME_COUNT_EN only)
// ---------------------------------------------------------------------------
module svga_timing_gen #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int FRAME_W    = 8,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int X_W       = $clog2(H_TOTAL),
    localparam int Y_W       = $clog2(V_TOTAL)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           active_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           next_vertical_o,
    output logic           next_frame_o
`ifdef SVGA_FRAME_COUNT_EN
    ,
    output logic [FRAME_W-1:0] frame_o
`endif
);

    // Region boundaries sized to the counters. Every boundary is strictly
    // below the total because every porch is at least one unit wide.
    localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [X_W-1:0] H_ONE      = X_W'(1);
    localparam logic [X_W-1:0] H_ZERO     = X_W'(0);

    localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [Y_W-1:0] V_ONE      = Y_W'(1);
    localparam logic [Y_W-1:0] V_ZERO     = Y_W'(0);

    localparam logic H_ON = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic V_ON = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;

    // Elaboration-time parameter sanity check.
    generate
        if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
            (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) ||
            (FRAME_W < 1)) begin : g_bad_param
            $error("svga_timing_gen: every timing parameter and FRAME_W must be >= 1");
        end
    endgenerate

    logic [X_W-1:0] h_r;
    logic [Y_W-1:0] v_r;
    logic           active_r;
    logic           hsync_r;
    logic           vsync_r;

    logic [X_W-1:0] h_nxt_s;
    logic [Y_W-1:0] v_nxt_s;
    logic           h_wrap_s;
    logic           v_wrap_s;
    logic           active_nxt_s;
    logic           hsync_nxt_s;
    logic           vsync_nxt_s;

    // Next raster position and the region flags of that position.
    always_comb begin
        h_wrap_s = (h_r == H_LAST);
        v_wrap_s = (v_r == V_LAST);

        if (h_wrap_s) begin
            h_nxt_s = H_ZERO;
            if (v_wrap_s) begin
                v_nxt_s = V_ZERO;
            end else begin
                v_nxt_s = v_r + V_ONE;
            end
        end else begin
            h_nxt_s = h_r + H_ONE;
            v_nxt_s = v_r;
        end

        active_nxt_s = (h_nxt_s < H_ACT_END) && (v_nxt_s < V_ACT_END);
        hsync_nxt_s  = ((h_nxt_s >= H_SYNC_BEG) && (h_nxt_s < H_SYNC_END)) ? H_ON : ~H_ON;
        vsync_nxt_s  = ((v_nxt_s >= V_SYNC_BEG) && (v_nxt_s < V_SYNC_END)) ? V_ON : ~V_ON;
    end

    // Position counters and registered raster outputs, advanced together so
    // sync/blanking never skew against the coordinates. The reset position
    // is the last pixel of the frame, which lies in both back porches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_r      <= H_LAST;
            v_r      <= V_LAST;
            active_r <= 1'b0;
            hsync_r  <= ~H_ON;
            vsync_r  <= ~V_ON;
        end else if (en_i) begin
            h_r      <= h_nxt_s;
            v_r      <= v_nxt_s;
            active_r <= active_nxt_s;
            hsync_r  <= hsync_nxt_s;
            vsync_r  <= vsync_nxt_s;
        end else begin
            h_r      <= h_r;
            v_r      <= v_r;
            active_r <= active_r;
            hsync_r  <= hsync_r;
            vsync_r  <= vsync_r;
        end
    end

    assign x_o      = h_r;
    assign y_o      = v_r;
    assign active_o = active_r;
    assign hsync_o  = hsync_r;
    assign vsync_o  = vsync_r;

    // Strobes are combinational so they coincide with the cycle whose edge
    // performs the wrap; gating with en_i keeps them low while stalled.
    assign next_vertical_o = en_i & h_wrap_s;
    assign next_frame_o    = en_i & h_wrap_s & v_wrap_s;

`ifdef SVGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_r;

    // Frame counter, stepped on every edge that leaves the last pixel of a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_r <= {FRAME_W{1'b0}};
        end else if (next_frame_o) begin
            frame_r <= frame_r + {{(FRAME_W-1){1'b0}}, 1'b1};
        end else begin
            frame_r <= frame_r;
        end
    end

    assign frame_o = frame_r;
`endif

endmodule
